alu_bcd_display: RTL and testbench

ALU_BCD_DISPLAY -- requirements
Module: alu_bcd_display

---
 rtl/alu_disp_pkg.sv | 52 +++++
 rtl/seg7_decode.sv | 26 ++
 rtl/alu_bcd_display.sv | 149 ++++++++++++++
 tb/tb_alu_bcd_display.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_disp_pkg
// Description : Shared definitions for the accumulator BCD display block:
//               converter FSM state encoding, the blank segment pattern and
//               the active-low {g,f,e,d,c,b,a} codes for decimal digits 0-9.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  // Codes 10-15 never occur in a valid BCD digit; they render as blank so a
  // corrupted digit is visibly wrong rather than mimicking a real number.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : One BCD digit to an active-low seven-segment pattern.
//   digit : 4-bit BCD digit
//   blank : 1 forces all segments off
//   seg   : active-low segments {g,f,e,d,c,b,a}
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
  import alu_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      seg = digit_to_seg(digit);
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_bcd_display.sv
`default_nettype none
// ============================================================================
// Module      : alu_bcd_display
// Description : Converts an 8-bit unsigned value to three BCD digits with a
//               sequential shift-add-3 (double dabble) engine, then drives
//               three seven-segment displays from the registered result.
//   Clock            : rising-edge clock
//   Reset_b          : asynchronous reset, active HIGH despite the name
//   Value[7:0]       : binary value, captured when a conversion starts
//   Start            : conversion request, honoured only when idle
//   Busy             : high while shifting
//   Done             : one-cycle pulse when Bcd/HEX carry a new result
//   Bcd[11:0]        : {hundreds, tens, ones}
//   HEX2, HEX1, HEX0 : active-low segments for hundreds / tens / ones
// Revision    : 1.0 - initial release
// ============================================================================
module alu_bcd_display
  import alu_disp_pkg::*;
#(
  parameter int BLANK_LEADING = 1
) (
  input  logic        Clock,
  input  logic        Reset_b,
  input  logic [7:0]  Value,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic [11:0] Bcd,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX0
);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_bin;
  logic [11:0] r_scratch;
  logic [2:0]  r_cnt;
  logic [11:0] r_bcd;
  logic [11:0] w_adjusted;
  logic [19:0] w_shifted;
  logic [2:0]  w_blank;
  logic [6:0]  w_seg [3];

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset_b) begin
    if (Reset_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    Busy         = 1'b0;
    Done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        Busy = 1'b1;
        if (r_cnt == 3'd7) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        Done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Double-dabble datapath
  // --------------------------------------------------------------------------
  always_comb begin
    w_adjusted = r_scratch;
    for (int i = 0; i < 3; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) begin
        w_adjusted[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // The scratch MSB is dropped: an 8-bit input never exceeds 2 hundreds, so
  // bit 11 of the scratch is always zero before the final shift.
  assign w_shifted = {w_adjusted[10:0], r_bin, 1'b0};

  always_ff @(posedge Clock or posedge Reset_b) begin
    if (Reset_b) begin
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_bin     <= Value;
            r_scratch <= '0;
            r_cnt     <= '0;
          end
        end
        ST_SHIFT: begin
          r_scratch <= w_shifted[19:8];
          r_bin     <= w_shifted[7:0];
          r_cnt     <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_bcd <= w_shifted[19:8];
          end
        end
        default: ;
      endcase
    end
  end

  assign Bcd = r_bcd;

  // --------------------------------------------------------------------------
  // Display decode
  // --------------------------------------------------------------------------
  // Tens are blanked only when hundreds are also zero, so 100..109 keep
  // their inner "0". The ones digit is always shown.
  assign w_blank[2] = (BLANK_LEADING != 0) && (r_bcd[11:8] == 4'd0);
  assign w_blank[1] = (BLANK_LEADING != 0) && (r_bcd[11:8] == 4'd0)
                      && (r_bcd[7:4] == 4'd0);
  assign w_blank[0] = 1'b0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_digit
    seg7_decode u_dec (
      .digit (r_bcd[4*gi +: 4]),
      .blank (w_blank[gi]),
      .seg   (w_seg[gi])
    );
  end

  assign HEX2 = w_seg[2];
  assign HEX1 = w_seg[1];
  assign HEX0 = w_seg[0];

endmodule
`default_nettype wire

// File: tb/tb_alu_bcd_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_bcd_display
// Description : Self-checking bench for alu_bcd_display. Two instances share
//               stimulus: one with leading-zero blanking, one without. The
//               expected digits come from decimal division of the value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_bcd_display;

  logic        Clock = 1'b0;
  logic        Reset_b;
  logic [7:0]  Value;
  logic        Start;
  logic        Busy, Done;
  logic [11:0] Bcd;
  logic [6:0]  HEX2, HEX1, HEX0;
  logic        Busy_nb, Done_nb;
  logic [11:0] Bcd_nb;
  logic [6:0]  HEX2_nb, HEX1_nb, HEX0_nb;

  int n_checks = 0;
  int n_pass   = 0;

  // Independent digit glyph table, active-low {g,f,e,d,c,b,a}
  logic [6:0] seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  alu_bcd_display #(.BLANK_LEADING(1)) dut (
    .Clock(Clock), .Reset_b(Reset_b), .Value(Value), .Start(Start),
    .Busy(Busy), .Done(Done), .Bcd(Bcd),
    .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0)
  );

  alu_bcd_display #(.BLANK_LEADING(0)) dut_nb (
    .Clock(Clock), .Reset_b(Reset_b), .Value(Value), .Start(Start),
    .Busy(Busy_nb), .Done(Done_nb), .Bcd(Bcd_nb),
    .HEX2(HEX2_nb), .HEX1(HEX1_nb), .HEX0(HEX0_nb)
  );

  always #5 Clock = ~Clock;

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [6:0] ref_seg(input int d, input bit blank);
    if (blank) return 7'h7f;
    return seg_ref[d];
  endfunction

  // Compare both instances' Bcd and segment outputs against the decimal
  // digits of v.
  task automatic check_display(input int v, input string tag);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    check_value({tag, "/bcd"},  {20'd0, Bcd},    (h << 8) | (t << 4) | o);
    check_value({tag, "/hex2"}, {25'd0, HEX2},   {25'd0, ref_seg(h, h == 0)});
    check_value({tag, "/hex1"}, {25'd0, HEX1},   {25'd0, ref_seg(t, h == 0 && t == 0)});
    check_value({tag, "/hex0"}, {25'd0, HEX0},   {25'd0, ref_seg(o, 1'b0)});
    check_value({tag, "/nb_bcd"},  {20'd0, Bcd_nb},  (h << 8) | (t << 4) | o);
    check_value({tag, "/nb_hex2"}, {25'd0, HEX2_nb}, {25'd0, ref_seg(h, 1'b0)});
    check_value({tag, "/nb_hex1"}, {25'd0, HEX1_nb}, {25'd0, ref_seg(t, 1'b0)});
    check_value({tag, "/nb_hex0"}, {25'd0, HEX0_nb}, {25'd0, ref_seg(o, 1'b0)});
  endtask

  // One conversion started by a single-cycle Start. Optionally a second
  // Start with a different Value is pulsed at shift cycle restart_at, which
  // must be ignored. Observes a fixed window of 14 cycles.
  task automatic run_conv(input int v, input int restart_at, input int alt_v,
                          input string tag);
    int busy_cnt, done_cnt, done_at;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    @(negedge Clock);
    Value = v[7:0];
    Start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge Clock);
      Start = 1'b0;
      if (restart_at != 0 && c == restart_at) begin
        Start = 1'b1;
        Value = alt_v[7:0];
      end
      if (Busy) busy_cnt++;
      if (Done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c;
          check_display(v, tag);
        end
      end
    end
    Start = 1'b0;
    check_value({tag, "/busy_cycles"}, busy_cnt, 8);
    check_value({tag, "/done_cycle"},  done_at,  9);
    check_value({tag, "/done_count"},  done_cnt, 1);
  endtask

  initial begin
    int v, last_done, idx, cyc, dn_cnt, bz_cnt;

    Reset_b = 1'b1;
    Start   = 1'b0;
    Value   = 8'd0;
    #12;
    check_value("rst/busy", Busy, 0);
    check_value("rst/done", Done, 0);
    check_value("rst/bcd",  Bcd,  0);
    check_value("rst/hex2", HEX2, 7'h7f);
    check_value("rst/hex1", HEX1, 7'h7f);
    check_value("rst/hex0", HEX0, 7'h40);
    check_value("rst/nb_hex2", HEX2_nb, 7'h40);
    check_value("rst/nb_hex1", HEX1_nb, 7'h40);
    check_value("rst/nb_hex0", HEX0_nb, 7'h40);
    @(negedge Clock);
    Reset_b = 1'b0;

    run_conv(255, 0, 0, "v255");
    run_conv(7,   0, 0, "v7");
    run_conv(100, 0, 0, "v100");
    run_conv(0,   0, 0, "v0");
    run_conv(109, 0, 0, "v109");

    repeat (20) begin
      v = int'($urandom_range(0, 255));
      run_conv(v, 0, 0, "rand");
    end

    // Start re-pulsed during shift with a new Value: ignored
    run_conv(200, 3, 13, "restart");

    // Result holds while Value wanders and Start stays low
    Value = 8'd77;
    repeat (5) @(negedge Clock);
    check_display(200, "hold");

    // Reset mid-shift
    @(negedge Clock);
    Value = 8'd99;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (3) @(negedge Clock);
    check_value("midrst/busy_before", Busy, 1);
    #2 Reset_b = 1'b1;
    #1;
    check_value("midrst/busy", Busy, 0);
    check_value("midrst/done", Done, 0);
    check_value("midrst/bcd",  Bcd,  0);
    check_value("midrst/nb_bcd", Bcd_nb, 0);
    @(negedge Clock);
    Reset_b = 1'b0;
    dn_cnt = 0;
    bz_cnt = 0;
    repeat (12) begin
      @(negedge Clock);
      if (Done) dn_cnt++;
      if (Busy) bz_cnt++;
    end
    check_value("midrst/no_done", dn_cnt, 0);
    check_value("midrst/no_busy", bz_cnt, 0);
    check_display(0, "midrst_disp");
    run_conv(42, 0, 0, "v42");

    // Sweep 0..255 with Start held high
    @(negedge Clock);
    Value     = 8'd0;
    Start     = 1'b1;
    idx       = 0;
    cyc       = 0;
    last_done = -1;
    while (idx < 256 && cyc < 3000) begin
      @(negedge Clock);
      cyc++;
      if (Done) begin
        check_display(idx, "sweep");
        if (idx > 0) check_value("sweep/spacing", cyc - last_done, 10);
        last_done = cyc;
        idx++;
        Value = idx[7:0];
      end
    end
    Start = 1'b0;
    check_value("sweep/count", idx, 256);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
